rc4_key_search_ctrl: RTL and testbench

- Top-level scheduler for one RC4 brute-force core. It owns the shared S-memory port and sequences three engines per key candidate: S-init, key-schedule shuffle, and the decrypt/validate engine.
- Walks key candidates from `key_first` upward in steps of `KEY_STEP`. Stops on the first key whose decrypted message is all valid ASCII, or when the range is exhausted.
- Sits between the board-level start/status logic and the three engines plus the S RAM.

---
 rtl/rc4_key_search_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_rc4_key_search_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_key_search_ctrl.sv
// Scheduler for one RC4 brute-force core: walks key candidates, sequences the
// S-init, key-schedule and decrypt engines and owns the shared S-memory port.
module rc4_key_search_ctrl #(
  parameter int                   KEY_WIDTH   = 24,
  parameter int                   KEY_STEP    = 1,
  parameter logic [KEY_WIDTH-1:0] KEY_LIMIT   = 24'h3FFFFF,
  parameter int                   WDOG_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [KEY_WIDTH-1:0] key_first,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 init_start,
  input  logic                 init_finish,
  output logic                 ksa_start,
  input  logic                 ksa_finish,
  output logic                 dec_start,
  input  logic                 dec_finish,
  input  logic                 dec_invalid,
  input  logic [7:0]           init_s_addr,
  input  logic [7:0]           init_s_data,
  input  logic                 init_s_wren,
  input  logic [7:0]           ksa_s_addr,
  input  logic [7:0]           ksa_s_data,
  input  logic                 ksa_s_wren,
  input  logic [7:0]           dec_s_addr,
  input  logic [7:0]           dec_s_data,
  input  logic                 dec_s_wren,
  output logic [7:0]           s_address,
  output logic [7:0]           s_data,
  output logic                 s_wren,
  output logic                 busy,
  output logic                 found,
  output logic                 fail,
  output logic                 wdog_err,
  output logic [KEY_WIDTH-1:0] keys_tried,
  output logic [3:0]           dbg_state
);

  // Engine handshake: *_start is a one-cycle pulse from the GO state; *_finish
  // is only honoured in the matching WAIT state and ignored everywhere else.
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_INIT_GO   = 4'd1;
  localparam logic [3:0] S_INIT_WAIT = 4'd2;
  localparam logic [3:0] S_KSA_GO    = 4'd3;
  localparam logic [3:0] S_KSA_WAIT  = 4'd4;
  localparam logic [3:0] S_DEC_GO    = 4'd5;
  localparam logic [3:0] S_DEC_WAIT  = 4'd6;
  localparam logic [3:0] S_NEXT      = 4'd7;
  localparam logic [3:0] S_FOUND     = 4'd8;
  localparam logic [3:0] S_FAIL      = 4'd9;
  localparam logic [3:0] S_ERR       = 4'd10;

  localparam int WDW = $clog2(WDOG_CYCLES + 1);

  logic [3:0]           state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [KEY_WIDTH-1:0] tried_q, tried_d;
  logic                 found_q, found_d;
  logic                 fail_q, fail_d;
  logic                 wdog_q, wdog_d;
  logic                 busy_q, busy_d;
  logic [WDW-1:0]       cnt_q, cnt_d;
  logic                 phase_finish;
  logic [KEY_WIDTH:0]   key_sum;

  always_comb begin
    phase_finish = 1'b0;
    case (state_q)
      S_INIT_WAIT: phase_finish = init_finish;
      S_KSA_WAIT:  phase_finish = ksa_finish;
      S_DEC_WAIT:  phase_finish = dec_finish;
      default:     phase_finish = 1'b0;
    endcase
  end

  assign key_sum = {1'b0, key_q} + (KEY_WIDTH+1)'(KEY_STEP);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    tried_d = tried_q;
    found_d = found_q;
    fail_d  = fail_q;
    wdog_d  = wdog_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          key_d   = key_first;
          tried_d = '0;
          found_d = 1'b0;
          wdog_d  = 1'b0;
          if (key_first > KEY_LIMIT) begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_INIT_GO;
            fail_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end
      // The counter holds cycles elapsed since the start pulse, so the GO
      // cycle itself counts as one; ERR begins WDOG_CYCLES after the pulse.
      S_INIT_GO: begin cnt_d = WDW'(1); state_d = S_INIT_WAIT; end
      S_KSA_GO:  begin cnt_d = WDW'(1); state_d = S_KSA_WAIT;  end
      S_DEC_GO:  begin cnt_d = WDW'(1); state_d = S_DEC_WAIT;  end
      S_INIT_WAIT, S_KSA_WAIT, S_DEC_WAIT: begin
        if (phase_finish) begin
          if (state_q == S_INIT_WAIT) begin
            state_d = S_KSA_GO;
          end else if (state_q == S_KSA_WAIT) begin
            state_d = S_DEC_GO;
          end else begin
            tried_d = tried_q + 1'b1;
            if (!dec_invalid) begin
              state_d = S_FOUND;
              found_d = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d = S_NEXT;
            end
          end
        end else if (cnt_q >= WDW'(WDOG_CYCLES - 1)) begin
          state_d = S_ERR;
          wdog_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_NEXT: begin
        // Sum is one bit wider so a wrap past KEY_WIDTH also ends the range.
        if (key_sum > {1'b0, KEY_LIMIT}) begin
          state_d = S_FAIL;
          fail_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          key_d   = key_sum[KEY_WIDTH-1:0];
          state_d = S_INIT_GO;
        end
      end
      S_FOUND, S_FAIL, S_ERR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      tried_q <= '0;
      found_q <= 1'b0;
      fail_q  <= 1'b0;
      wdog_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      tried_q <= tried_d;
      found_q <= found_d;
      fail_q  <= fail_d;
      wdog_q  <= wdog_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    s_address = 8'h00;
    s_data    = 8'h00;
    s_wren    = 1'b0;
    case (state_q)
      S_INIT_GO, S_INIT_WAIT: begin
        s_address = init_s_addr; s_data = init_s_data; s_wren = init_s_wren;
      end
      S_KSA_GO, S_KSA_WAIT: begin
        s_address = ksa_s_addr;  s_data = ksa_s_data;  s_wren = ksa_s_wren;
      end
      S_DEC_GO, S_DEC_WAIT: begin
        s_address = dec_s_addr;  s_data = dec_s_data;  s_wren = dec_s_wren;
      end
      default: begin
        s_address = 8'h00; s_data = 8'h00; s_wren = 1'b0;
      end
    endcase
  end

  assign init_start = (state_q == S_INIT_GO);
  assign ksa_start  = (state_q == S_KSA_GO);
  assign dec_start  = (state_q == S_DEC_GO);
  assign key        = key_q;
  assign keys_tried = tried_q;
  assign busy       = busy_q;
  assign found      = found_q;
  assign fail       = fail_q;
  assign wdog_err   = wdog_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl: behavioural engine models, a per-cycle S-port
// and handshake checker, and directed plus randomized key searches.
module tb_rc4_key_search_ctrl;
  localparam int KW    = 24;
  localparam int STEP  = 1;
  localparam int LIMIT = 'h3FFFFF;
  localparam int WDOG  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] key_first = '0;
  logic [KW-1:0] key, keys_tried;
  logic          init_start, ksa_start, dec_start;
  logic          init_finish = 1'b0, ksa_finish = 1'b0, dec_finish = 1'b0;
  logic          dec_invalid = 1'b0;
  logic [7:0]    init_s_addr = '0, init_s_data = '0;
  logic [7:0]    ksa_s_addr = '0, ksa_s_data = '0;
  logic [7:0]    dec_s_addr = '0, dec_s_data = '0;
  logic          init_s_wren = 1'b0, ksa_s_wren = 1'b0, dec_s_wren = 1'b0;
  logic [7:0]    s_address, s_data;
  logic          s_wren, busy, found, fail, wdog_err;
  logic [3:0]    dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rc4_key_search_ctrl #(
    .KEY_WIDTH(KW), .KEY_STEP(STEP), .KEY_LIMIT(24'h3FFFFF), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .key_first(key_first), .key(key),
    .init_start(init_start), .init_finish(init_finish),
    .ksa_start(ksa_start), .ksa_finish(ksa_finish),
    .dec_start(dec_start), .dec_finish(dec_finish), .dec_invalid(dec_invalid),
    .init_s_addr(init_s_addr), .init_s_data(init_s_data), .init_s_wren(init_s_wren),
    .ksa_s_addr(ksa_s_addr), .ksa_s_data(ksa_s_data), .ksa_s_wren(ksa_s_wren),
    .dec_s_addr(dec_s_addr), .dec_s_data(dec_s_data), .dec_s_wren(dec_s_wren),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren),
    .busy(busy), .found(found), .fail(fail), .wdog_err(wdog_err),
    .keys_tried(keys_tried), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Engine models and search context shared with the main sequence.
  int dmin = 2, dmax = 12;
  bit ksa_hang = 1'b0, wren_all = 1'b0;
  int init_cnt = 0, ksa_cnt = 0, dec_cnt = 0;
  int n_init = 0, n_ksa = 0, n_dec = 0;
  int run_first = 0, run_match = 0;
  int phase = 0, age = 0;
  logic prev_is = 1'b0, prev_ks = 1'b0, prev_ds = 1'b0;
  logic [7:0] ea, ed;
  logic       ew;

  // Phase: 0 none, 1 init, 2 ksa, 3 dec. An engine owns the S port from its
  // start pulse through the cycle its finish is sampled, or until timeout.
  always @(negedge clk) begin
    if (reset) begin
      phase = 0;
      check("rst_busy", 32'(busy), 0);
      check("rst_starts", 32'({init_start, ksa_start, dec_start}), 0);
    end else begin
      if ((phase == 1 && init_finish) || (phase == 2 && ksa_finish) ||
          (phase == 3 && dec_finish)) phase = 0;
      if (phase != 0) begin
        age++;
        if (age >= WDOG) phase = 0;
      end
      if (init_start) begin phase = 1; age = 0; n_init++; end
      else if (ksa_start) begin phase = 2; age = 0; n_ksa++; end
      else if (dec_start) begin
        phase = 3; age = 0; n_dec++;
        check("key_at_dec", 32'(key), run_first + STEP * (n_dec - 1));
      end
      if (dec_finish) begin
        check("found_latency", 32'(found), 32'(!dec_invalid));
        check("busy_after_dec", 32'(busy), 32'(dec_invalid));
      end
    end
    case (phase)
      1:       {ea, ed, ew} = {init_s_addr, init_s_data, init_s_wren};
      2:       {ea, ed, ew} = {ksa_s_addr, ksa_s_data, ksa_s_wren};
      3:       {ea, ed, ew} = {dec_s_addr, dec_s_data, dec_s_wren};
      default: {ea, ed, ew} = 17'h0;
    endcase
    check("s_address", 32'(s_address), 32'(ea));
    check("s_data", 32'(s_data), 32'(ed));
    check("s_wren", 32'(s_wren), 32'(ew));
    check("start_pulse_width",
          32'({init_start & prev_is, ksa_start & prev_ks, dec_start & prev_ds}), 0);
    prev_is = init_start; prev_ks = ksa_start; prev_ds = dec_start;

    // Drive next-cycle engine responses.
    init_finish = 1'b0; ksa_finish = 1'b0; dec_finish = 1'b0;
    dec_invalid = 1'($urandom_range(1, 0));
    if (reset) begin
      init_cnt = 0; ksa_cnt = 0; dec_cnt = 0;
    end else begin
      if (init_cnt > 0) begin init_cnt--; if (init_cnt == 0) init_finish = 1'b1; end
      if (ksa_cnt > 0)  begin ksa_cnt--;  if (ksa_cnt == 0)  ksa_finish = 1'b1; end
      if (dec_cnt > 0) begin
        dec_cnt--;
        if (dec_cnt == 0) begin
          dec_finish  = 1'b1;
          dec_invalid = ((run_first + STEP * (n_dec - 1)) != run_match);
        end
      end
      if (init_start) init_cnt = int'($urandom_range(dmax, dmin));
      if (ksa_start && !ksa_hang) ksa_cnt = int'($urandom_range(dmax, dmin));
      if (dec_start) dec_cnt = int'($urandom_range(dmax, dmin));
    end
    init_s_addr = 8'($urandom); init_s_data = 8'($urandom);
    ksa_s_addr  = 8'($urandom); ksa_s_data  = 8'($urandom);
    dec_s_addr  = 8'($urandom); dec_s_data  = 8'($urandom);
    init_s_wren = wren_all ? 1'b1 : 1'($urandom_range(1, 0));
    ksa_s_wren  = wren_all ? 1'b1 : 1'($urandom_range(1, 0));
    dec_s_wren  = wren_all ? 1'b1 : 1'($urandom_range(1, 0));
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic begin_search(input int first, input int match);
    run_first = first; run_match = match;
    n_init = 0; n_ksa = 0; n_dec = 0;
    key_first = KW'(first);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_search(input int first, input int match, input bit poke);
    int cyc, exp_tried, exp_key;
    bit exp_found;
    begin_search(first, match);
    if (first > LIMIT) begin
      check("oor_busy", 32'(busy), 0);
    end else begin
      check("start_latency", 32'(init_start), 1);
      check("busy_on_start", 32'(busy), 1);
    end
    cyc = 0;
    while (busy && cyc < 20000) begin
      if (poke && cyc == 7) begin key_first = ~key_first; start = 1'b1; end
      else start = 1'b0;
      step();
      cyc++;
    end
    start = 1'b0;
    check("search_in_budget", 32'(cyc < 20000), 1);
    if (first > LIMIT) begin
      exp_found = 1'b0; exp_tried = 0; exp_key = first;
    end else if (match >= first && match <= LIMIT && (match - first) % STEP == 0) begin
      exp_found = 1'b1; exp_tried = (match - first) / STEP + 1; exp_key = match;
    end else begin
      exp_found = 1'b0; exp_tried = (LIMIT - first) / STEP + 1;
      exp_key = first + STEP * (exp_tried - 1);
    end
    check("found", 32'(found), 32'(exp_found));
    check("fail", 32'(fail), 32'(!exp_found));
    check("wdog_err", 32'(wdog_err), 0);
    check("key", 32'(key), exp_key);
    check("keys_tried", 32'(keys_tried), exp_tried);
    check("init_pulses", n_init, exp_tried);
    check("ksa_pulses", n_ksa, exp_tried);
    check("dec_pulses", n_dec, exp_tried);
    step();
    check("found_sticky", 32'(found), 32'(exp_found));
    check("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    int cyc, first;
    reset = 1'b1;
    repeat (3) step();
    check("reset_key", 32'(key), 0);
    check("reset_tried", 32'(keys_tried), 0);
    check("reset_flags", 32'({busy, found, fail, wdog_err}), 0);
    check("reset_s_port", 32'({s_address, s_data, s_wren}), 0);
    reset = 1'b0;
    step();

    dmin = 10; dmax = 10;
    run_search(5, 5, 1'b0);
    dmin = 2; dmax = 12;
    run_search(0, 3, 1'b0);
    run_search('h3FFFFE, 'hFFFFFF, 1'b0);
    run_search('h400000, 0, 1'b0);
    wren_all = 1'b1;
    run_search(20, 22, 1'b0);

    // Shuffle engine never answers: the watchdog must end the search.
    ksa_hang = 1'b1;
    begin_search(50, 50);
    cyc = 0;
    while (!ksa_start && cyc < 200) begin step(); cyc++; end
    check("reach_ksa", 32'(ksa_start), 1);
    cyc = 0;
    while (!wdog_err && cyc < 200) begin step(); cyc++; end
    check("wdog_delay", cyc, WDOG);
    check("wdog_flags", 32'({busy, found, fail, wdog_err}), 1);
    check("wdog_tried", 32'(keys_tried), 0);
    check("wdog_dec_pulses", n_dec, 0);
    step(); step();
    check("wdog_s_wren", 32'(s_wren), 0);
    check("wdog_sticky", 32'(wdog_err), 1);
    ksa_hang = 1'b0;
    wren_all = 1'b0;

    // Reset in the middle of a decrypt phase, then restart the same range.
    dmin = 4; dmax = 8;
    begin_search(100, 103);
    cyc = 0;
    while (!dec_start && cyc < 500) begin step(); cyc++; end
    check("reach_dec", 32'(dec_start), 1);
    step();
    reset = 1'b1;
    step();
    check("midrst_busy", 32'(busy), 0);
    check("midrst_starts", 32'({init_start, ksa_start, dec_start}), 0);
    check("midrst_s_wren", 32'(s_wren), 0);
    check("midrst_tried", 32'(keys_tried), 0);
    reset = 1'b0;
    step();
    dmin = 2; dmax = 12;
    run_search(100, 103, 1'b0);

    for (int i = 0; i < 6; i++) begin
      first = int'($urandom_range(5000, 0));
      run_search(first, first + int'($urandom_range(4, 0)), 1'(i % 2));
    end
    for (int i = 0; i < 2; i++) begin
      first = LIMIT - int'($urandom_range(3, 0));
      run_search(first, 'hFFFFFF, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
